// File: rtl/au_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package au_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 bit, for counters that must exist even when NWORDS=1.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p * 2) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/AU_addsub_c.sv
// Combinational WIDTH-bit adder/subtractor; in subtract mode ci/co are borrow-in/borrow-out.
module AU_addsub_c #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             add_sub,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned WP1 = WIDTH + 1;

    logic [WIDTH-1:0] bx;
    logic             cin;
    logic             cout;

    // a - b - bin == a + ~b + ~bin; the raw carry is the inverse of the borrow.
    assign bx  = b ^ {WIDTH{add_sub}};
    assign cin = ci ^ add_sub;
    assign co  = cout ^ add_sub;

    // ARCH 0 builds an explicit ripple chain; other values leave the prefix structure to synthesis.
    generate
        if (ARCH == 0) begin : g_ripple
            logic c;
            always_comb begin
                s = '0;
                c = cin;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    s[i] = a[i] ^ bx[i] ^ c;
                    c    = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
                end
                cout = c;
            end
        end else begin : g_prefix
            assign {cout, s} = WP1'(a) + WP1'(bx) + WP1'(cin);
        end
    endgenerate

endmodule

// File: rtl/au_addsub_mp_seq.sv
// N-bit add/subtract computed one WIDTH-bit chunk per cycle, LSW first, with a registered carry chain.
module au_addsub_mp_seq
    import au_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NWORDS = 4,
    parameter int unsigned ARCH   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*NWORDS-1:0]    a,
    input  logic [WIDTH*NWORDS-1:0]    b,
    input  logic                       ci,
    input  logic                       add_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*NWORDS-1:0]    s,
    output logic                       co,
    output logic                       ovf
);

    localparam int unsigned N  = WIDTH * NWORDS;
    localparam int unsigned CW = clog2_min1(NWORDS);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             sub_q;
    logic             carry_q;
    logic             msa_q;
    logic             msb_q;
    logic [N-1:0]     s_q;
    logic             co_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] chunk_a;
    logic [WIDTH-1:0] chunk_b;
    logic [WIDTH-1:0] chunk_s;
    logic             chunk_co;
    logic             last_c;

    // Select chunk k of the latched operands.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned k = 0; k < NWORDS; k++) begin
            if (cnt_q == CW'(k)) begin
                chunk_a = a_q[k*WIDTH +: WIDTH];
                chunk_b = b_q[k*WIDTH +: WIDTH];
            end
        end
    end

    assign last_c = (cnt_q == CW'(NWORDS - 1));

    AU_addsub_c #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_chunk (
        .a       (chunk_a),
        .b       (chunk_b),
        .ci      (carry_q),
        .add_sub (sub_q),
        .s       (chunk_s),
        .co      (chunk_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= add_sub;
                        carry_q <= ci;
                        msa_q   <= a[N-1];
                        msb_q   <= b[N-1] ^ add_sub;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int unsigned k = 0; k < NWORDS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            s_q[k*WIDTH +: WIDTH] <= chunk_s;
                        end
                    end
                    carry_q <= chunk_co;
                    if (last_c) begin
                        // Top chunk's msb is the result msb, so overflow resolves here.
                        co_q        <= chunk_co;
                        ovf_q       <= (msa_q == msb_q) && (chunk_s[WIDTH-1] != msa_q);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule
